decoder_nto2n_seq: RTL
======================

// Module: decoder_nto2n_seq
// PURPOSE
//   Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with valid/ready command input.
//   Supports static decode plus an auto-sweep mode that walks the one-hot output with a programmable dwell time.
//   Drives row/bank/channel selects, e.g. a scanned display or round-robin peripheral enables.
// PARAMETERS
//   SEL_W    3   select width; OUT_W = 1<<SEL_W (localparam)
//   DWELL_W  8   width of per-position dwell count
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        command valid
//   in_ready   out  1        command accepted when in_valid && in_ready at a rising edge
//   in_mode    in   2        0 DECODE, 1 SCAN_UP, 2 SCAN_DOWN, 3 CLEAR
//   in_sel     in   SEL_W    decode index / scan start position
//   in_dwell   in   DWELL_W  extra cycles held per scan position
//   out        out  OUT_W    registered one-hot output (all-zero when idle)
//   out_valid  out  1        out carries a live selection
//   pos        out  SEL_W    index currently driven on out
//   done       out  1        one-cycle pulse at the end of a scan
// BEHAVIOUR
//   - Reset: state IDLE; out=0, out_valid=0, pos=0, done=0, in_ready=1. Reset mid-scan aborts, no done pulse.
//   - States: IDLE, HOLD, SCAN. Latency: command accepted at edge k -> out updated at edge k+1 (all outputs registered).
//   - DECODE: out=1<<in_sel, pos=in_sel, out_valid=1 -> HOLD. Output held until the next accepted command.
//   - CLEAR: out=0, out_valid=0, pos unchanged -> IDLE.
//   - IDLE/HOLD: in_ready=1; any accepted command replaces the current one with no gap cycle.
//   - SCAN_UP/DOWN: pos=in_sel, out=1<<in_sel; latch dwell; in_ready=0 for the whole scan.
//   - Each position is held in_dwell+1 cycles; dwell=0 advances every cycle.
//   - pos +1 (UP) / -1 (DOWN) modulo OUT_W: wraps OUT_W-1->0 and 0->OUT_W-1.
//   - Exactly OUT_W positions are visited: total OUT_W*(dwell+1) valid cycles.
//   - Cycle after the last dwell: out=0, out_valid=0, done=1 for one cycle -> IDLE, in_ready=1.
//   - in_valid while in_ready=0 is ignored; nothing is captured and the source must hold.
//   - out always has either exactly one bit set (out_valid=1) or zero bits set (out_valid=0).
//   - Dwell counter is DWELL_W bits, counts down from the latched value, no overflow possible.
// CONFIGURATION
//   Macro DECODER_SCAN_EN:
//   - defined: full behaviour above.
//   - undefined: SCAN_UP/SCAN_DOWN act as DECODE of in_sel; in_dwell unused; no SCAN state;
//     in_ready tied 1; done tied 0.
// STRUCTURE
//   - Package decoder_pkg:
//       mode encoding enum (DECODE/SCAN_UP/SCAN_DOWN/CLEAR, 2 bits)
//       state enum (IDLE/HOLD/SCAN)
//   - Sub-module onehot_dec: purely combinational SEL_W->OUT_W one-hot function, parametrised on SEL_W;
//     instantiated once, output registered in the top.
//   - Top holds the FSM, pos register, dwell counter, scan-step counter, output registers.
// TESTING (SEL_W=3, DWELL_W=8)
//   1. rst=1 two cycles -> out=8'h00, out_valid=0, pos=0, done=0, in_ready=1.
//   2. DECODE sel=5 -> next cycle out=8'h20, out_valid=1; back-to-back DECODE sel=0 -> out=8'h01 on the following cycle.
//   3. SCAN_UP sel=6 dwell=1 -> out 40,40,80,80,01,01,...,20,20 (16 cycles, in_ready=0);
//      then out=00, done=1 for one cycle, in_ready=1.
//   4. SCAN_DOWN sel=0 dwell=0 -> out 01,80,40,20,10,08,04,02, then done.
//      A DECODE with in_valid=1 mid-scan is not accepted and the output sequence is unchanged.
//   5. SCAN_UP sel=0 dwell=3, rst=1 on the 5th scan cycle -> out=00, out_valid=0 next cycle; done never pulses.
//   6. DECODER_SCAN_EN undefined: SCAN_UP sel=3 -> out=8'h08 held, in_ready stays 1, done stays 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types for the sequenced one-hot decoder.
//   mode_e  : command mode carried on in_mode
//   state_e : controller states of decoder_nto2n_seq
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE    = 2'd0,
    MODE_SCAN_UP   = 2'd1,
    MODE_SCAN_DOWN = 2'd2,
    MODE_CLEAR     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational SEL_W -> 2^SEL_W one-hot decoder.
//   sel : binary index
//   out : one-hot vector with bit 'sel' set
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] out
);

  always_comb begin
    out      = '0;
    out[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered one-hot decoder with valid/ready command input and an optional
// auto-sweep mode that walks the one-hot output with a programmable dwell.
//
// Build macro: DECODER_SCAN_EN
//   defined   : SCAN_UP / SCAN_DOWN sweep all OUT_W positions, then pulse done
//   undefined : scan modes decode in_sel like DECODE, in_ready=1, done=0
//
// Ports
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   in_valid   : command valid
//   in_ready   : command accepted when in_valid && in_ready at a rising edge
//   in_mode    : 0 DECODE, 1 SCAN_UP, 2 SCAN_DOWN, 3 CLEAR
//   in_sel     : decode index / scan start position
//   in_dwell   : extra cycles held per scan position
//   out        : registered one-hot output, zero when nothing selected
//   out_valid  : out carries a live selection
//   pos        : index currently driven on out
//   done       : one-cycle pulse after the last scan position
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | nothing selected, ready for a command
// ST_HOLD | static selection held, ready for a command
// ST_SCAN | sweeping positions, commands blocked (in_ready=0)
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [DWELL_W-1:0] in_dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   pos,
  output logic               done
);

  state_e             state, state_n;
  logic [SEL_W-1:0]   pos_r, pos_n;
  logic               valid_r, valid_n;
  logic [OUT_W-1:0]   out_r, out_n;
  logic [OUT_W-1:0]   dec_out;
  logic               accept;
  mode_e              mode;

  assign mode   = mode_e'(in_mode);
  assign accept = in_valid && in_ready;

`ifdef DECODER_SCAN_EN
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
  logic [DWELL_W-1:0] dwell_lat, dwell_lat_n;
  // Positions still to be visited after the current one.
  logic [SEL_W-1:0]   step_cnt, step_cnt_n;
  logic               dir_up, dir_up_n;
  logic               done_r, done_n;

  assign in_ready = (state != ST_SCAN);
  assign done     = done_r;
`else
  logic unused_dwell;
  assign unused_dwell = ^in_dwell;
  assign in_ready     = 1'b1;
  assign done         = 1'b0;
`endif

  // Single decoder instance fed with the next position so out is registered.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel (pos_n),
    .out (dec_out)
  );

  always_comb begin
    state_n = state;
    pos_n   = pos_r;
    valid_n = valid_r;
`ifdef DECODER_SCAN_EN
    dwell_cnt_n = dwell_cnt;
    dwell_lat_n = dwell_lat;
    step_cnt_n  = step_cnt;
    dir_up_n    = dir_up;
    done_n      = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          case (mode)
            MODE_CLEAR: begin
              valid_n = 1'b0;
              state_n = ST_IDLE;
            end
`ifdef DECODER_SCAN_EN
            MODE_SCAN_UP, MODE_SCAN_DOWN: begin
              pos_n       = in_sel;
              valid_n     = 1'b1;
              dwell_cnt_n = in_dwell;
              dwell_lat_n = in_dwell;
              step_cnt_n  = '1;
              dir_up_n    = (mode == MODE_SCAN_UP);
              state_n     = ST_SCAN;
            end
`endif
            default: begin
              pos_n   = in_sel;
              valid_n = 1'b1;
              state_n = ST_HOLD;
            end
          endcase
        end
      end
`ifdef DECODER_SCAN_EN
      ST_SCAN: begin
        if (dwell_cnt != '0) begin
          dwell_cnt_n = dwell_cnt - 1'b1;
        end else if (step_cnt != '0) begin
          pos_n       = dir_up ? pos_r + 1'b1 : pos_r - 1'b1;
          dwell_cnt_n = dwell_lat;
          step_cnt_n  = step_cnt - 1'b1;
        end else begin
          valid_n = 1'b0;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
      end
    endcase
    out_n = valid_n ? dec_out : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pos_r   <= '0;
      valid_r <= 1'b0;
      out_r   <= '0;
    end else begin
      state   <= state_n;
      pos_r   <= pos_n;
      valid_r <= valid_n;
      out_r   <= out_n;
    end
  end

`ifdef DECODER_SCAN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      dwell_lat <= '0;
      step_cnt  <= '0;
      dir_up    <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      dwell_cnt <= dwell_cnt_n;
      dwell_lat <= dwell_lat_n;
      step_cnt  <= step_cnt_n;
      dir_up    <= dir_up_n;
      done_r    <= done_n;
    end
  end
`endif

  assign out       = out_r;
  assign out_valid = valid_r;
  assign pos       = pos_r;

endmodule
